regfile_n: RTL and testbench
============================

# regfile_n

Parametrised general-purpose register file, the successor to the fixed 8×8 register bank. It provides NREG registers of W bits each and two independent combinational read ports. It has a multi-register write/function port with eight operations, including shifts and rotate, and a sticky per-register wrap flag. Optional saturating arithmetic and load-to-read bypass are set by parameters. It sits between the ALU output/memory data bus and the ALU A/B operand inputs.

## Interface
- W, 8, register width in bits (≥2)
- NREG, 8, number of registers (2..16)
- SAT, 0, 1 = increment/decrement saturate instead of wrapping
- BYPASS, 0, 1 = read port forwards `load` when reading a register being loaded this cycle
- RESET_VAL, 0, value of every register after reset

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  W  data for load operation
- rsel  input  NREG  register select, any combination of bits; bit i = register i takes the operation
- funsel  input  3  operation applied to all selected registers
- o1sel  input  clog2(NREG)  read port 1 address
- o2sel  input  clog2(NREG)  read port 2 address
- o1  output  W  contents of register o1sel
- o2  output  W  contents of register o2sel
- wrap  output  NREG  sticky wrap/saturation flag per register

## Operation
- funsel encoding (selected registers only; unselected registers hold):
  - 000 hold
  - 001 load (Q = load)
  - 010 increment
  - 011 decrement
  - 100 clear (Q = 0)
  - 101 shift left, 0 fill
  - 110 logical shift right, 0 fill
  - 111 rotate left by 1
- Arithmetic is modulo 2^W when SAT=0.
  - Increment from all-ones gives 0 and sets wrap[i].
  - Decrement from 0 gives all-ones and sets wrap[i].
- When SAT=1, increment at all-ones and decrement at 0 leave Q unchanged and set wrap[i].
- wrap[i] is sticky: it clears only on reset, or on load/clear of register i. Set and clear cannot coincide, because they come from different funsel codes.
- Shifts and rotate never affect wrap.
- Multiple rsel bits: each selected register independently applies the same operation to its own value. rsel = 0 is a no-op.
- Read ports are combinational from register state. o1sel and o2sel may be equal.
- An address ≥ NREG (when NREG is not a power of two) reads 0.
- BYPASS=1: if funsel=001 and rsel[oNsel]=1, oN = load in the same cycle, combinationally. No other operation is forwarded.
- BYPASS=0: reads always show the pre-edge value.

## Timing
- Reset (rst_n low, asynchronous, no clock required):
  - all registers = RESET_VAL
  - wrap = 0
  - o1/o2 reflect RESET_VAL immediately
- Reset deassertion is synchronous-release safe. The first update happens on the first rising edge with rst_n high.
- Reset asserted mid-operation overrides any pending operation. No partial update survives.
- Write latency is 1 cycle: the operation takes effect at the rising edge, and the new value appears on o1/o2 after that edge.
- Read latency is 0 cycles (combinational).
- wrap updates on the same edge as the offending increment/decrement.
- Inputs must be stable for setup/hold around the rising clk edge. There is no handshake; an operation is issued every cycle funsel≠000 and rsel≠0.

## Test plan
- Reset: W=8, NREG=8, RESET_VAL=0x5A. Pulse rst_n low between edges → all o1/o2 reads = 0x5A and wrap = 0x00 before any clock edge.
- Load and multi-select increment:
  - rsel=0x05, funsel=001, load=0x95 → R0 = R2 = 0x95, others unchanged.
  - Then funsel=010 for two cycles → R0 = R2 = 0x97.
  - o1sel=0 and o2sel=2 both read 0x97.
- Wrap: load R3=0xFF, increment → R3=0x00, wrap[3]=1.
  - wrap[3] is still 1 after a decrement (R3=0xFF).
  - Clear R3 → R3=0x00, wrap[3]=0.
  - SAT=1 variant: increment at 0xFF keeps 0xFF and sets wrap[3]=1.
- Shift and rotate: R1=0x95.
  - funsel=101 → 0x2A
  - funsel=110 → 0x15
  - funsel=111 → 0x2A
  - wrap[1] unchanged throughout.
- Bypass: BYPASS=1, R4=0x00, rsel=0x10, funsel=001, load=0x3C, o1sel=4 → o1 = 0x3C before the edge, and stays 0x3C after the edge. BYPASS=0: o1 = 0x00 before the edge, 0x3C after.
- Reset mid-run: assert rst_n low while funsel=010 is active on all registers → the next edge produces no increment, and all registers = RESET_VAL until release.

Source files
------------

// File: rtl/regfile_n.sv
// regfile_n: NREG x W register file with two combinational read ports, a
// multi-select write/function port, and a sticky per-register wrap flag.
// SAT selects saturating inc/dec; BYPASS forwards load data to the read ports.

// One register plus its wrap flag; applies funsel when sel is high.
module regfile_n_cell #(
    parameter int              W         = 8,
    parameter bit              SAT       = 1'b0,
    parameter logic [W-1:0]    RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sel,
    input  logic [2:0]   funsel,
    input  logic [W-1:0] load,
    output logic [W-1:0] q,
    output logic         wrap
);
    logic [W-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;

    // Next-state: operation on own value; wrap set only by inc/dec overflow,
    // cleared only by load/clear, untouched by shifts and rotate.
    always_comb begin
        q_d    = q_q;
        wrap_d = wrap_q;
        if (sel) begin
            unique case (funsel)
                3'b000: ;
                3'b001: begin q_d = load; wrap_d = 1'b0; end
                3'b010: begin
                    if (&q_q) begin
                        wrap_d = 1'b1;
                        q_d    = SAT ? q_q : '0;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end
                3'b011: begin
                    if (q_q == '0) begin
                        wrap_d = 1'b1;
                        q_d    = SAT ? q_q : '1;
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
                3'b100: begin q_d = '0; wrap_d = 1'b0; end
                3'b101: q_d = {q_q[W-2:0], 1'b0};
                3'b110: q_d = {1'b0, q_q[W-1:1]};
                3'b111: q_d = {q_q[W-2:0], q_q[W-1]};
                default: ;
            endcase
        end
    end

    // State register; reset wins over any pending operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
endmodule

module regfile_n #(
    parameter int           W         = 8,
    parameter int           NREG      = 8,
    parameter bit           SAT       = 1'b0,
    parameter bit           BYPASS    = 1'b0,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [W-1:0]              load,
    input  logic [NREG-1:0]           rsel,
    input  logic [2:0]                funsel,
    input  logic [$clog2(NREG)-1:0]   o1sel,
    input  logic [$clog2(NREG)-1:0]   o2sel,
    output logic [W-1:0]              o1,
    output logic [W-1:0]              o2,
    output logic [NREG-1:0]           wrap
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][W-1:0] regs;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        regfile_n_cell #(
            .W         (W),
            .SAT       (SAT),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .sel    (rsel[i]),
            .funsel (funsel),
            .load   (load),
            .q      (regs[i]),
            .wrap   (wrap[i])
        );
    end

    // Read mux by compare-loop so unpopulated addresses fall through to 0
    // without indexing past the array.
    function automatic logic [W-1:0] rd_port(input logic [AW-1:0] a);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(a) == i) begin
                v = regs[i];
                if (BYPASS && funsel == 3'b001 && rsel[i]) v = load;
            end
        end
        return v;
    endfunction

    // Combinational read ports (with optional load forwarding).
    always_comb begin
        o1 = rd_port(o1sel);
        o2 = rd_port(o2sel);
    end
endmodule

// File: tb/tb_regfile_n.sv
// Directed bench for regfile_n: three instances share stimulus
//   a: W8 NREG8 wrapping, no bypass     b: W8 NREG8 saturating, bypass
//   c: W8 NREG6 (out-of-range reads)    all RESET_VAL = 0x5A
module tb_regfile_n;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] load = '0;
    logic [7:0] rsel = '0;
    logic [2:0] funsel = '0;
    logic [2:0] o1sel = '0, o2sel = '0;
    logic [2:0] o1sel_c = '0, o2sel_c = '0;
    logic [7:0] o1a, o2a, wrapa, o1b, o2b, wrapb, o1c, o2c;
    logic [5:0] wrapc;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    regfile_n #(.W(8), .NREG(8), .SAT(1'b0), .BYPASS(1'b0), .RESET_VAL(8'h5A)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .rsel(rsel), .funsel(funsel),
        .o1sel(o1sel), .o2sel(o2sel), .o1(o1a), .o2(o2a), .wrap(wrapa));
    regfile_n #(.W(8), .NREG(8), .SAT(1'b1), .BYPASS(1'b1), .RESET_VAL(8'h5A)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .rsel(rsel), .funsel(funsel),
        .o1sel(o1sel), .o2sel(o2sel), .o1(o1b), .o2(o2b), .wrap(wrapb));
    regfile_n #(.W(8), .NREG(6), .SAT(1'b0), .BYPASS(1'b0), .RESET_VAL(8'h5A)) dut_c (
        .clk(clk), .rst_n(rst_n), .load(load), .rsel(rsel[5:0]), .funsel(funsel),
        .o1sel(o1sel_c), .o2sel(o2sel_c), .o1(o1c), .o2(o2c), .wrap(wrapc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] s, input logic [2:0] f, input logic [7:0] d);
        rsel = s; funsel = f; load = d;
    endtask

    task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
        o1sel = a1; o2sel = a2;
        #1;
    endtask

    initial begin
        // Reset pulse between edges, checked before any edge
        #2 rst_n = 1'b0;
        o1sel = 3'd0; o2sel = 3'd7; o1sel_c = 3'd5; o2sel_c = 3'd7;
        #1;
        chk("rst_o1", o1a, 8'h5A);
        chk("rst_o2", o2a, 8'h5A);
        chk("rst_wrap", wrapa, 8'h00);
        chk("rst_c_r5", o1c, 8'h5A);
        chk("rst_c_oor", o2c, 8'h00);
        #1 rst_n = 1'b1;
        tick();

        // Load R0,R2 = 0x95; bypass instance forwards before the edge
        op(8'h05, 3'b001, 8'h95);
        rd(3'd0, 3'd1);
        chk("byp0_pre", o1a, 8'h5A);
        chk("byp1_pre", o1b, 8'h95);
        chk("byp1_unsel", o2b, 8'h5A);
        tick();
        op(8'h05, 3'b010, 8'h00);
        rd(3'd0, 3'd2);
        chk("ld_r0", o1a, 8'h95);
        chk("ld_r2", o2a, 8'h95);
        tick(); tick();
        op(8'h00, 3'b000, 8'h00);
        rd(3'd0, 3'd2);
        chk("inc_r0", o1a, 8'h97);
        chk("inc_r2", o2a, 8'h97);
        chk("inc_b_r0", o1b, 8'h97);
        rd(3'd1, 3'd3);
        chk("inc_r1_hold", o1a, 8'h5A);
        o1sel_c = 3'd0; o2sel_c = 3'd6;
        #1;
        chk("c_r0", o1c, 8'h97);
        chk("c_oor6", o2c, 8'h00);

        // Wrap on R3
        op(8'h08, 3'b001, 8'hFF); tick();
        op(8'h08, 3'b010, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00);
        rd(3'd3, 3'd3);
        chk("inc_wrap_q", o1a, 8'h00);
        chk("inc_wrap_f", wrapa, 8'h08);
        chk("sat_inc_q", o1b, 8'hFF);
        chk("sat_inc_f", wrapb, 8'h08);
        op(8'h08, 3'b011, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("dec_q", o1a, 8'hFF);
        chk("dec_sticky", wrapa, 8'h08);
        chk("sat_dec_q", o1b, 8'hFE);
        op(8'h08, 3'b100, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("clr_q", o1a, 8'h00);
        chk("clr_f", wrapa, 8'h00);
        chk("clr_b_f", wrapb, 8'h00);
        // Decrement from 0, then shift keeps the wrap flag
        op(8'h08, 3'b011, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("dec0_q", o1a, 8'hFF);
        chk("dec0_f", wrapa, 8'h08);
        chk("sat_dec0_q", o1b, 8'h00);
        chk("sat_dec0_f", wrapb, 8'h08);
        op(8'h08, 3'b101, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("shl_r3", o1a, 8'hFE);
        chk("shl_keep_f", wrapa, 8'h08);

        // Shift/rotate on R1 = 0x95
        op(8'h02, 3'b001, 8'h95); tick();
        op(8'h02, 3'b101, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00);
        rd(3'd1, 3'd1);
        chk("shl", o1a, 8'h2A);
        op(8'h02, 3'b110, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("shr", o1a, 8'h15);
        op(8'h02, 3'b111, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("rol", o1a, 8'h2A);
        op(8'h02, 3'b001, 8'h81); tick();
        op(8'h02, 3'b111, 8'h00); tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("rol_msb", o1a, 8'h03);
        chk("rot_wrap", wrapa, 8'h08);

        // Bypass on R4
        op(8'h10, 3'b100, 8'h00); tick();
        op(8'h10, 3'b001, 8'h3C);
        rd(3'd4, 3'd4);
        chk("byp_a_pre", o1a, 8'h00);
        chk("byp_b_pre", o1b, 8'h3C);
        tick();
        op(8'h10, 3'b010, 8'h00); #1;
        chk("byp_a_post", o1a, 8'h3C);
        chk("byp_b_noinc", o1b, 8'h3C);
        tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("byp_b_inc", o1b, 8'h3D);

        // Reset mid-run while incrementing everything
        op(8'hFF, 3'b010, 8'h00);
        rst_n = 1'b0;
        rd(3'd0, 3'd7);
        chk("mid_rst_r0", o1a, 8'h5A);
        tick();
        chk("mid_rst_r7", o2a, 8'h5A);
        chk("mid_rst_f", wrapa, 8'h00);
        chk("mid_rst_b", o1b, 8'h5A);
        #3 rst_n = 1'b1;
        tick();
        op(8'h00, 3'b000, 8'h00); #1;
        chk("post_rel_inc", o1a, 8'h5B);
        chk("post_rel_r7", o2a, 8'h5B);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
